ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, frame constants, default timing and the parity helper.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W      = $clog2(PS2_FRAME_BITS);

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;
    localparam int unsigned DEF_FILTER_LEN     = 8;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    // Byte being shifted out together with its precomputed parity bit.
    typedef struct packed {
        logic                     parity;
        logic [PS2_DATA_BITS-1:0] data;
    } ps2_tx_frame_t;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the control side and the PS/2 host transmitter.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] tx_data;
    logic                     tx_start;
    logic                     busy;
    logic                     tx_done;
    logic                     tx_error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for a PS/2 line.
// The filtered level only changes after FILTER_LEN consecutive samples agree.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize, count disagreeing samples, flip the level after a full run.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_in};
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                cnt_q <= '0;
                level <= sync_q[1];
                fall  <= level;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// one command byte out on device clock falls and checks the device ack.
// Optional: define PS2_HOST_TX_TIMEOUT_EN to add the inter-fall watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_bad_params
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2, FILTER_LEN >= 1");
    end

    ps2_tx_state_e        state_q, state_d;
    logic [INH_W-1:0]     inh_q, inh_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    ps2_tx_frame_t        frame_q, frame_d;
    logic [1:0]           d_sync_q;
    logic                 c_oe_d, d_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 c_level, c_fall;
    logic                 d_sync;

    assign d_sync        = d_sync_q[1];
    assign host.busy     = busy_q;
    assign host.tx_done  = done_q;
    assign host.tx_error = err_q;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2c_in),
        .level   (c_level),
        .fall    (c_fall)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;

    // Watchdog: cycles since the last device clock fall while the device owns the clock.
    always_comb begin
        wd_d       = '0;
        wd_expired = 1'b0;
        if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
            if (c_fall) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_expired = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Next-state and registered-output logic for the transmit sequence.
    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        c_oe_d  = ps2c_oe;
        d_oe_d  = ps2d_oe;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host.tx_start) begin
                    frame_d.data   = host.tx_data;
                    frame_d.parity = odd_parity(host.tx_data);
                    inh_d          = '0;
                    busy_d         = 1'b1;
                    c_oe_d         = 1'b1;
                    state_d        = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_d = inh_q + INH_W'(1);
                if (inh_q == INH_W'(INHIBIT_CYCLES - 2)) begin
                    d_oe_d = 1'b1;
                end
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    inh_d   = '0;
                    c_oe_d  = 1'b0;
                    bit_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (c_fall) begin
                    bit_d = bit_q + BIT_IDX_W'(1);
                    if (bit_q < BIT_IDX_W'(PS2_DATA_BITS)) begin
                        d_oe_d = ~frame_q.data[bit_q[2:0]];
                    end else if (bit_q == BIT_IDX_W'(PS2_DATA_BITS)) begin
                        d_oe_d = ~frame_q.parity;
                    end else begin
                        d_oe_d  = 1'b0;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (c_fall) begin
                    if (!d_sync) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (c_level && d_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        if (wd_expired) begin
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            inh_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            d_sync_q <= 2'b11;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inh_q    <= inh_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            d_sync_q <= {d_sync_q[0], ps2d_in};
            ps2c_oe  <= c_oe_d;
            ps2d_oe  <= d_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule
